// File: rtl/floo_wormhole_wrr_arbiter.sv
// rtl/floo_wormhole_wrr_arbiter.sv - weighted round-robin wormhole arbiter for a router output port

// Default flit layout; any replacement flit type must provide hdr.last.
package floo_wormhole_wrr_arbiter_pkg;

    typedef struct packed {
        logic       last;
        logic [3:0] src;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [15:0] payload;
    } flit_t;

endpackage

module floo_wormhole_wrr_arbiter #(
    parameter int unsigned NumRoutes   = 2,
    parameter int unsigned WeightWidth = 4,
    parameter type         flit_t      = floo_wormhole_wrr_arbiter_pkg::flit_t,
    localparam int unsigned IdxW       = (NumRoutes > 1) ? $clog2(NumRoutes) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumRoutes-1:0][WeightWidth-1:0] weight_i,
    input  logic [NumRoutes-1:0]                  valid_i,
    output logic [NumRoutes-1:0]                  ready_o,
    input  flit_t [NumRoutes-1:0]                 data_i,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output flit_t                                 data_o,
    output logic                                  locked_o,
    output logic [IdxW-1:0]                       lock_idx_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                                state_q;
    logic [IdxW-1:0]                       rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]                       lock_idx_q;
    logic [NumRoutes-1:0][WeightWidth-1:0] credit_q, credit_d;

    logic [NumRoutes-1:0][WeightWidth-1:0] eff_w;
    logic [NumRoutes-1:0][WeightWidth-1:0] eff_credit;
    logic [NumRoutes-1:0]                  eligible;
    logic                                  any_valid;
    logic                                  need_reload;
    logic [IdxW-1:0]                       pick;
    logic                                  found;
    logic [IdxW-1:0]                       sel;
    flit_t                                 sel_flit;
    logic                                  hs;
    logic                                  done;

    // A zero weight still grants one packet per round, so clamp it to 1.
    always_comb begin
        eff_w = '0;
        for (int i = 0; i < NumRoutes; i++) begin
            eff_w[i] = (weight_i[i] == '0) ? WeightWidth'(1) : weight_i[i];
        end
    end

    // Detect the end of a round: requests exist but none has credit left.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumRoutes; i++) begin
            eligible[i] = valid_i[i] && (credit_q[i] != '0);
        end
        any_valid   = |valid_i;
        need_reload = (state_q == IDLE) && any_valid && !(|eligible);
        eff_credit  = need_reload ? eff_w : credit_q;
    end

    // Cyclic search for the first credited requester at or after rr_ptr.
    always_comb begin
        logic [IdxW:0] slot;
        pick  = '0;
        found = 1'b0;
        slot  = '0;
        for (int off = 0; off < NumRoutes; off++) begin
            slot = {1'b0, rr_ptr_q} + (IdxW+1)'(off);
            if (slot >= (IdxW+1)'(NumRoutes)) begin
                slot = slot - (IdxW+1)'(NumRoutes);
            end
            if (!found && valid_i[slot[IdxW-1:0]] && (eff_credit[slot[IdxW-1:0]] != '0)) begin
                found = 1'b1;
                pick  = slot[IdxW-1:0];
            end
        end
    end

    // Output mux: a locked input owns the link, bubbles included.
    always_comb begin
        sel        = (state_q == LOCKED) ? lock_idx_q : pick;
        sel_flit   = data_i[sel];
        valid_o    = (state_q == LOCKED) ? valid_i[lock_idx_q] : found;
        data_o     = valid_o ? sel_flit : '0;
        ready_o    = '0;
        if (state_q == LOCKED || found) begin
            ready_o[sel] = ready_i;
        end
        lock_idx_o = (state_q == IDLE && found) ? pick : lock_idx_q;
        locked_o   = (state_q == LOCKED);
        hs         = valid_o && ready_i;
        done       = hs && sel_flit.hdr.last;
    end

    // Credit bookkeeping: reload at round end, charge one credit per finished packet.
    always_comb begin
        credit_d = need_reload ? eff_w : credit_q;
        rr_ptr_d = rr_ptr_q;
        if (done) begin
            if (credit_d[sel] != '0) begin
                credit_d[sel] = credit_d[sel] - WeightWidth'(1);
            end
            if (credit_d[sel] == '0) begin
                rr_ptr_d = (sel == IdxW'(NumRoutes - 1)) ? '0 : sel + IdxW'(1);
            end else begin
                rr_ptr_d = sel;
            end
        end
    end

    // Packet lock FSM plus arbitration state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            credit_q   <= eff_w;
        end else begin
            credit_q <= credit_d;
            rr_ptr_q <= rr_ptr_d;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        lock_idx_q <= sel;
                        if (!sel_flit.hdr.last) begin
                            state_q <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floo_wormhole_wrr_arbiter.sv
// tb/tb_floo_wormhole_wrr_arbiter.sv - directed self-checking bench for the wormhole WRR arbiter
module tb_floo_wormhole_wrr_arbiter;
    import floo_wormhole_wrr_arbiter_pkg::*;

    localparam int N = 3;
    localparam int W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0][W-1:0] weight;
    logic [N-1:0]      valid;
    logic [N-1:0]      ready_o;
    flit_t [N-1:0]     data;
    logic              valid_o;
    logic              ready_i;
    flit_t             data_o;
    logic              locked_o;
    logic [1:0]        lock_idx_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    floo_wormhole_wrr_arbiter #(
        .NumRoutes  (N),
        .WeightWidth(W),
        .flit_t     (flit_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .weight_i  (weight),
        .valid_i   (valid),
        .ready_o   (ready_o),
        .data_i    (data),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .locked_o  (locked_o),
        .lock_idx_o(lock_idx_o)
    );

    function automatic flit_t mk(input logic last, input logic [3:0] src, input logic [15:0] pl);
        flit_t f;
        f.hdr.last = last;
        f.hdr.src  = src;
        f.payload  = pl;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2);
        weight[0] = w0;
        weight[1] = w1;
        weight[2] = w2;
        rst     = 1'b1;
        valid   = '0;
        ready_i = 1'b1;
        data    = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        weight  = '{default: 4'd1};
        rst     = 1'b1;
        valid   = '0;
        ready_i = 1'b1;
        data    = '0;
        tick();
        @(negedge clk);
        n_tests++;
        if ({valid_o, ready_o, data_o, locked_o, lock_idx_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid_o=%0b ready_o=%b data_o=%h locked_o=%0b lock_idx_o=%0d, required all zero",
                     valid_o, ready_o, data_o, locked_o, lock_idx_o);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++;
            if ({valid_o, ready_o, data_o, locked_o} !== '0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: valid_o=%0b ready_o=%b data_o=%h locked_o=%0b, required all zero",
                         c, valid_o, ready_o, data_o, locked_o);
            end
            tick();
        end
    endtask

    task automatic test_equal_weights();
        do_reset(4'd1, 4'd1, 4'd1);
        valid = 3'b111;
        for (int i = 0; i < N; i++) data[i] = mk(1'b1, 4'(i), 16'(i));
        for (int c = 0; c < 9; c++) begin
            int exp_idx;
            exp_idx = c % 3;
            @(negedge clk);
            n_tests++;
            if (lock_idx_o !== 2'(exp_idx) || ready_o !== 3'(1 << exp_idx) ||
                data_o.hdr.src !== 4'(exp_idx) || valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL equal_rr%0d: idx=%0d ready_o=%b src=%0d valid_o=%0b, required idx=%0d",
                         c, lock_idx_o, ready_o, data_o.hdr.src, valid_o, exp_idx);
            end
            tick();
        end
    endtask

    task automatic test_weighted();
        int exp_seq [4] = '{0, 0, 1, 2};
        int cnt0;
        cnt0 = 0;
        do_reset(4'd2, 4'd1, 4'd1);
        valid = 3'b111;
        for (int i = 0; i < N; i++) data[i] = mk(1'b1, 4'(i), 16'(i));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (valid_o && ready_i && lock_idx_o == 2'd0) cnt0++;
            if (c < 8) begin
                n_tests++;
                if (lock_idx_o !== 2'(exp_seq[c % 4]) || data_o.hdr.src !== 4'(exp_seq[c % 4])) begin
                    n_fail++;
                    $display("FAIL wrr_order%0d: idx=%0d src=%0d, required %0d",
                             c, lock_idx_o, data_o.hdr.src, exp_seq[c % 4]);
                end
            end
            tick();
        end
        n_tests++;
        if (cnt0 !== 20) begin
            n_fail++;
            $display("FAIL wrr_share: input0 grants=%0d of 40, required 20", cnt0);
        end
    endtask

    task automatic test_wormhole();
        logic v1   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic l1   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset(4'd1, 4'd1, 4'd1);
        // Spend input 0's credit so the pointer moves to input 1.
        valid   = 3'b001;
        data[0] = mk(1'b1, 4'd0, 16'h00A0);
        @(negedge clk);
        tick();
        data[0] = mk(1'b1, 4'd0, 16'h00B0);
        for (int j = 0; j < 6; j++) begin
            valid   = {1'b0, v1[j], 1'b1};
            data[1] = mk(l1[j], 4'd1, 16'h1000 + 16'(j));
            @(negedge clk);
            n_tests++;
            if (valid_o !== v1[j] || ready_o !== 3'b010 || locked_o !== (j != 0) ||
                lock_idx_o !== 2'd1 || (v1[j] && data_o.payload !== 16'h1000 + 16'(j))) begin
                n_fail++;
                $display("FAIL wormhole_step%0d: valid_o=%0b ready_o=%b locked_o=%0b idx=%0d payload=%h, required valid=%0b ready=010 locked=%0b idx=1",
                         j, valid_o, ready_o, locked_o, lock_idx_o, data_o.payload, v1[j], (j != 0));
            end
            tick();
        end
        valid = 3'b001;
        @(negedge clk);
        n_tests++;
        if (valid_o !== 1'b1 || ready_o !== 3'b001 || locked_o !== 1'b0 ||
            lock_idx_o !== 2'd0 || data_o.payload !== 16'h00B0) begin
            n_fail++;
            $display("FAIL wormhole_release: valid_o=%0b ready_o=%b locked_o=%0b idx=%0d payload=%h, required 1 001 0 0 00b0",
                     valid_o, ready_o, locked_o, lock_idx_o, data_o.payload);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset(4'd1, 4'd1, 4'd1);
        valid   = 3'b011;
        data[1] = mk(1'b1, 4'd1, 16'h1111);
        data[0] = mk(1'b0, 4'd0, 16'h0001);
        @(negedge clk);
        tick();
        data[0] = mk(1'b0, 4'd0, 16'h0002);
        ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (valid_o !== 1'b1 || data_o !== mk(1'b0, 4'd0, 16'h0002) || ready_o !== 3'b000 ||
                locked_o !== 1'b1 || lock_idx_o !== 2'd0) begin
                n_fail++;
                $display("FAIL backpressure%0d: valid_o=%0b data_o=%h ready_o=%b locked_o=%0b idx=%0d, required 1 flit2 000 1 0",
                         c, valid_o, data_o, ready_o, locked_o, lock_idx_o);
            end
            tick();
        end
        ready_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ready_o !== 3'b001 || data_o.payload !== 16'h0002) begin
            n_fail++;
            $display("FAIL bp_resume: ready_o=%b payload=%h, required 001 0002", ready_o, data_o.payload);
        end
        tick();
        data[0] = mk(1'b1, 4'd0, 16'h0003);
        @(negedge clk);
        tick();
        @(negedge clk);
        n_tests++;
        if (lock_idx_o !== 2'd1 || locked_o !== 1'b0 || data_o.payload !== 16'h1111) begin
            n_fail++;
            $display("FAIL bp_next_pkt: idx=%0d locked_o=%0b payload=%h, required 1 0 1111",
                     lock_idx_o, locked_o, data_o.payload);
        end
        tick();
    endtask

    task automatic test_reset_locked();
        do_reset(4'd1, 4'd1, 4'd1);
        valid   = 3'b100;
        data[2] = mk(1'b0, 4'd2, 16'h2000);
        @(negedge clk);
        tick();
        valid   = 3'b101;
        data[0] = mk(1'b1, 4'd0, 16'h0777);
        data[2] = mk(1'b0, 4'd2, 16'h2001);
        @(negedge clk);
        n_tests++;
        if (locked_o !== 1'b1 || lock_idx_o !== 2'd2 || ready_o !== 3'b100) begin
            n_fail++;
            $display("FAIL lock_on_2: locked_o=%0b idx=%0d ready_o=%b, required 1 2 100",
                     locked_o, lock_idx_o, ready_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (locked_o !== 1'b0 || lock_idx_o !== 2'd0 || ready_o !== 3'b001 ||
            valid_o !== 1'b1 || data_o.payload !== 16'h0777) begin
            n_fail++;
            $display("FAIL reset_mid_pkt: locked_o=%0b idx=%0d ready_o=%b valid_o=%0b payload=%h, required 0 0 001 1 0777",
                     locked_o, lock_idx_o, ready_o, valid_o, data_o.payload);
        end
        tick();
    endtask

    task automatic test_max_weight();
        // Weight 15 is the counter maximum; weight 0 on input 1 must act as 1.
        do_reset(4'd15, 4'd0, 4'd1);
        valid = 3'b011;
        for (int i = 0; i < N; i++) data[i] = mk(1'b1, 4'(i), 16'(i));
        for (int c = 0; c < 17; c++) begin
            int exp_idx;
            exp_idx = (c == 15) ? 1 : 0;
            @(negedge clk);
            n_tests++;
            if (lock_idx_o !== 2'(exp_idx) || valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL max_weight%0d: idx=%0d valid_o=%0b, required idx=%0d",
                         c, lock_idx_o, valid_o, exp_idx);
            end
            tick();
        end
    endtask

    initial begin
        weight  = '0;
        valid   = '0;
        data    = '0;
        ready_i = 1'b1;
        test_reset();
        test_equal_weights();
        test_weighted();
        test_wormhole();
        test_backpressure();
        test_reset_locked();
        test_max_weight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
